// File: rtl/a23_copro_sequencer.sv
// ---------------------------------------------------------------------------
// a23_copro_sequencer
//
// Sequences MCR/MRC instructions from the core to a single coprocessor.
// A request is decoded and latched when accepted in IDLE, issued to the
// coprocessor for one or more cycles in ISSUE (held there while the core
// is stalled), optionally waits a cycle for registered read data (MRC),
// then presents a response that is held until the consumer accepts it.
// Requests for any other coprocessor number, or words that are not a
// coprocessor register transfer, complete immediately as undefined.
//
// Ports
//   i_clk, i_rst_n            clock, asynchronous active-low reset
//   i_fetch_stall             core-wide stall; only unstalled edges issue
//   i_req_valid/o_req_ready   request handshake (ready only in IDLE)
//   i_req_instr               MCR/MRC instruction word
//   i_req_wdata               Rd value transferred by MCR
//   o_copro_*                 operation and decoded fields to coprocessor
//   i_copro_read_data         registered MRC read data (cycle after issue)
//   o_rsp_*                   response: valid, rd, data, undef, is_read
//   i_rsp_ready               response handshake
// ---------------------------------------------------------------------------
module a23_copro_sequencer #(
    parameter logic [3:0] COPRO_NUM = 4'd15
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic        i_fetch_stall,

    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_req_instr,
    input  logic [31:0] i_req_wdata,

    output logic [2:0]  o_copro_opcode1,
    output logic [2:0]  o_copro_opcode2,
    output logic [3:0]  o_copro_crn,
    output logic [3:0]  o_copro_crm,
    output logic [3:0]  o_copro_num,
    output logic [1:0]  o_copro_operation,
    output logic [31:0] o_copro_write_data,
    input  logic [31:0] i_copro_read_data,

    output logic        o_rsp_valid,
    output logic [3:0]  o_rsp_rd,
    output logic [31:0] o_rsp_data,
    output logic        o_rsp_undef,
    output logic        o_rsp_is_read,
    input  logic        i_rsp_ready
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT_RD,
        RESP
    } state_t;

    localparam logic [1:0] OP_NOP = 2'b00;
    localparam logic [1:0] OP_MRC = 2'b01;
    localparam logic [1:0] OP_MCR = 2'b10;

    state_t state;

    // Instruction decode of the word currently offered on the request port.
    logic [2:0] dec_opc1;
    logic       dec_load;
    logic [3:0] dec_crn;
    logic [3:0] dec_rd;
    logic [3:0] dec_cpnum;
    logic [2:0] dec_opc2;
    logic [3:0] dec_crm;
    logic       dec_legal;

    assign dec_opc1  = i_req_instr[23:21];
    assign dec_load  = i_req_instr[20];
    assign dec_crn   = i_req_instr[19:16];
    assign dec_rd    = i_req_instr[15:12];
    assign dec_cpnum = i_req_instr[11:8];
    assign dec_opc2  = i_req_instr[7:5];
    assign dec_crm   = i_req_instr[3:0];

    // Only coprocessor register transfers (cond-independent 1110 class with
    // bit 4 set) to our own coprocessor number are executed.
    assign dec_legal = (i_req_instr[27:24] == 4'b1110) && i_req_instr[4]
                       && (dec_cpnum == COPRO_NUM);

    // All outputs come straight from flops; req_ready, operation and
    // rsp_valid are updated together with the state so they never glitch.
    // NOTE: every register below is written with non-blocking assignments so
    // all flops sample the same pre-edge values, independent of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        // NOTE: reset clears every output register, not just the state, so an
        // aborted operation leaves no stale fields or data visible.
        if (!i_rst_n) begin
            state              <= IDLE;
            o_req_ready        <= 1'b1;
            o_copro_operation  <= OP_NOP;
            o_copro_opcode1    <= '0;
            o_copro_opcode2    <= '0;
            o_copro_crn        <= '0;
            o_copro_crm        <= '0;
            o_copro_num        <= '0;
            o_copro_write_data <= '0;
            o_rsp_valid        <= 1'b0;
            o_rsp_rd           <= '0;
            o_rsp_data         <= '0;
            o_rsp_undef        <= 1'b0;
            o_rsp_is_read      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_req_valid) begin
                        o_copro_opcode1    <= dec_opc1;
                        o_copro_opcode2    <= dec_opc2;
                        o_copro_crn        <= dec_crn;
                        o_copro_crm        <= dec_crm;
                        o_copro_num        <= dec_cpnum;
                        o_rsp_rd           <= dec_rd;
                        // Write data is only meaningful for a legal MCR.
                        o_copro_write_data <= (dec_legal && !dec_load) ? i_req_wdata : '0;
                        // Cleared here; MRC fills it in WAIT_RD, all others stay 0.
                        o_rsp_data         <= '0;
                        o_rsp_undef        <= !dec_legal;
                        o_rsp_is_read      <= dec_legal && dec_load;
                        o_req_ready        <= 1'b0;
                        if (dec_legal) begin
                            state             <= ISSUE;
                            o_copro_operation <= dec_load ? OP_MRC : OP_MCR;
                        end else begin
                            // Undefined: skip the coprocessor entirely.
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                        end
                    end
                end

                ISSUE: begin
                    // The coprocessor only acts on unstalled edges, so the
                    // operation is held until one occurs.
                    if (!i_fetch_stall) begin
                        o_copro_operation <= OP_NOP;
                        if (o_rsp_is_read) begin
                            state <= WAIT_RD;
                        end else begin
                            state       <= RESP;
                            o_rsp_valid <= 1'b1;
                        end
                    end
                end

                WAIT_RD: begin
                    // Read data is registered in the coprocessor and valid
                    // this cycle whatever the stall does now.
                    o_rsp_data  <= i_copro_read_data;
                    state       <= RESP;
                    o_rsp_valid <= 1'b1;
                end

                RESP: begin
                    if (i_rsp_ready) begin
                        state       <= IDLE;
                        o_rsp_valid <= 1'b0;
                        o_req_ready <= 1'b1;
                    end
                end

                default: begin
                    state             <= IDLE;
                    o_req_ready       <= 1'b1;
                    o_copro_operation <= OP_NOP;
                    o_rsp_valid       <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_a23_copro_sequencer.sv
// ---------------------------------------------------------------------------
// tb_a23_copro_sequencer
//
// Self-checking bench. Each transaction is described by its instruction,
// write data, number of stalled issue edges, number of backpressured
// response cycles and the value the coprocessor returns. From these the
// bench works out the whole expected cycle-by-cycle picture (latency,
// issue window, response contents) and compares every cycle.
// ---------------------------------------------------------------------------
module tb_a23_copro_sequencer;

    logic        i_clk = 1'b0;
    logic        i_rst_n;
    logic        i_fetch_stall;
    logic        i_req_valid;
    logic        o_req_ready;
    logic [31:0] i_req_instr;
    logic [31:0] i_req_wdata;
    logic [2:0]  o_copro_opcode1;
    logic [2:0]  o_copro_opcode2;
    logic [3:0]  o_copro_crn;
    logic [3:0]  o_copro_crm;
    logic [3:0]  o_copro_num;
    logic [1:0]  o_copro_operation;
    logic [31:0] o_copro_write_data;
    logic [31:0] i_copro_read_data;
    logic        o_rsp_valid;
    logic [3:0]  o_rsp_rd;
    logic [31:0] o_rsp_data;
    logic        o_rsp_undef;
    logic        o_rsp_is_read;
    logic        i_rsp_ready;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 i_clk = ~i_clk;

    a23_copro_sequencer #(.COPRO_NUM(4'd15)) dut (
        .i_clk              (i_clk),
        .i_rst_n            (i_rst_n),
        .i_fetch_stall      (i_fetch_stall),
        .i_req_valid        (i_req_valid),
        .o_req_ready        (o_req_ready),
        .i_req_instr        (i_req_instr),
        .i_req_wdata        (i_req_wdata),
        .o_copro_opcode1    (o_copro_opcode1),
        .o_copro_opcode2    (o_copro_opcode2),
        .o_copro_crn        (o_copro_crn),
        .o_copro_crm        (o_copro_crm),
        .o_copro_num        (o_copro_num),
        .o_copro_operation  (o_copro_operation),
        .o_copro_write_data (o_copro_write_data),
        .i_copro_read_data  (i_copro_read_data),
        .o_rsp_valid        (o_rsp_valid),
        .o_rsp_rd           (o_rsp_rd),
        .o_rsp_data         (o_rsp_data),
        .o_rsp_undef        (o_rsp_undef),
        .o_rsp_is_read      (o_rsp_is_read),
        .i_rsp_ready        (i_rsp_ready)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    function automatic logic is_legal(input logic [31:0] instr);
        return instr[27:24] == 4'hE && instr[4] == 1'b1 && instr[11:8] == 4'hF;
    endfunction

    // Everything that must read as zero while reset is asserted.
    task automatic check_reset_outputs(input string tag);
        check({tag, "_op"},        64'(o_copro_operation), 64'(0));
        check({tag, "_rsp_valid"}, 64'(o_rsp_valid), 64'(0));
        check({tag, "_undef"},     64'(o_rsp_undef), 64'(0));
        check({tag, "_fields"},    64'({o_copro_opcode1, o_copro_opcode2, o_copro_crn,
                                        o_copro_crm, o_copro_num}), 64'(0));
        check({tag, "_wdata"},     64'(o_copro_write_data), 64'(0));
        check({tag, "_rsp"},       64'({o_rsp_rd, o_rsp_data, o_rsp_is_read}), 64'(0));
    endtask

    // One full transaction from the IDLE cycle in which it is offered to the
    // last response cycle. Cycle 0 is the accept cycle; cycle k is the k-th
    // cycle after the accept edge.
    task automatic run_txn(input logic [31:0] instr, input logic [31:0] wdata,
                           input int n_stall, input int n_bp, input logic [31:0] rdv);
        logic        legal;
        logic        rd_op;
        int          lat;
        int          fin;
        logic [1:0]  op;
        logic [17:0] fld;
        logic [31:0] exp_data;
        legal    = is_legal(instr);
        rd_op    = instr[20];
        // Latency: undef 1, MCR 2, MRC 3, plus one per stalled issue edge.
        lat      = !legal ? 1 : ((rd_op ? 3 : 2) + n_stall);
        fin      = lat + n_bp;
        op       = !legal ? 2'b00 : (rd_op ? 2'b01 : 2'b10);
        fld      = {instr[23:21], instr[7:5], instr[19:16], instr[3:0], instr[11:8]};
        exp_data = (legal && rd_op) ? rdv : 32'h0;

        @(negedge i_clk);
        check("idle_req_ready", 64'(o_req_ready), 64'(1));
        check("idle_op",        64'(o_copro_operation), 64'(0));
        check("idle_rsp_valid", 64'(o_rsp_valid), 64'(0));
        i_req_valid       = 1'b1;
        i_req_instr       = instr;
        i_req_wdata       = wdata;
        i_fetch_stall     = 1'($urandom_range(0, 1));
        i_rsp_ready       = 1'($urandom_range(0, 1));
        i_copro_read_data = $urandom;

        for (int k = 1; k <= fin; k++) begin
            @(negedge i_clk);
            check("op", 64'(o_copro_operation),
                  64'((legal && k <= n_stall + 1) ? op : 2'b00));
            check("req_ready_busy", 64'(o_req_ready), 64'(0));
            check("rsp_valid", 64'(o_rsp_valid), 64'(k >= lat));
            check("fields", 64'({o_copro_opcode1, o_copro_opcode2, o_copro_crn,
                                 o_copro_crm, o_copro_num}), 64'(fld));
            check("write_data", 64'(o_copro_write_data),
                  64'((legal && !rd_op) ? wdata : 32'h0));
            if (k >= lat) begin
                check("rsp_rd",    64'(o_rsp_rd), 64'(instr[15:12]));
                check("rsp_data",  64'(o_rsp_data), 64'(exp_data));
                check("rsp_undef", 64'(o_rsp_undef), 64'(!legal));
                if (legal) check("rsp_is_read", 64'(o_rsp_is_read), 64'(rd_op));
            end
            // Inputs for cycle k: stall pattern only matters in the issue
            // window, ready only from the first response cycle on.
            if (legal && k <= n_stall)            i_fetch_stall = 1'b1;
            else if (legal && k == n_stall + 1)   i_fetch_stall = 1'b0;
            else                                  i_fetch_stall = 1'($urandom_range(0, 1));
            i_rsp_ready       = (k < lat) ? 1'($urandom_range(0, 1)) : (k == fin);
            i_copro_read_data = (legal && rd_op && k == n_stall + 2) ? rdv : $urandom;
            // Requests offered while busy must be ignored.
            i_req_valid       = 1'($urandom_range(0, 1));
            i_req_instr       = $urandom;
            i_req_wdata       = $urandom;
        end
        i_req_valid = 1'b0;
    endtask

    // Start an MRC, let it run for 'run_cycles' cycles after accept (with
    // i_fetch_stall held at 'stall'), then assert reset between edges.
    task automatic reset_mid_op(input string tag, input logic [31:0] instr,
                                input int run_cycles, input logic stall,
                                input logic [1:0] exp_op_before);
        @(negedge i_clk);
        i_req_valid   = 1'b1;
        i_req_instr   = instr;
        i_req_wdata   = $urandom;
        i_fetch_stall = stall;
        i_rsp_ready   = 1'b1;
        for (int k = 1; k <= run_cycles; k++) begin
            @(negedge i_clk);
            i_req_valid = 1'b0;
        end
        check({tag, "_op_before"}, 64'(o_copro_operation), 64'(exp_op_before));
        check({tag, "_crn_before"}, 64'(o_copro_crn), 64'(instr[19:16]));
        i_rst_n = 1'b0;
        #1;
        check_reset_outputs(tag);
        check({tag, "_ready_in_reset"}, 64'(o_req_ready), 64'(1));
        #2;
        i_rst_n       = 1'b1;
        i_fetch_stall = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge i_clk);
            check({tag, "_ready_after"}, 64'(o_req_ready), 64'(1));
            check({tag, "_no_rsp"},      64'(o_rsp_valid), 64'(0));
            check({tag, "_op_after"},    64'(o_copro_operation), 64'(0));
        end
    endtask

    initial begin
        logic [31:0] instr;
        int          kind;
        i_rst_n           = 1'b0;
        i_fetch_stall     = 1'b0;
        i_req_valid       = 1'b0;
        i_req_instr       = '0;
        i_req_wdata       = '0;
        i_copro_read_data = '0;
        i_rsp_ready       = 1'b0;

        repeat (2) @(negedge i_clk);
        check_reset_outputs("por");
        check("por_ready", 64'(o_req_ready), 64'(1));
        i_rst_n = 1'b1;

        // Directed scenarios.
        run_txn(32'hEE023F10, 32'h0000_0001, 0, 0, 32'h0);          // MCR, no stall
        run_txn(32'hEE105F10, 32'h1234_5678, 0, 0, 32'h4156_0300);  // MRC ID register
        run_txn(32'hEE105F10, 32'h0,         4, 0, 32'h4156_0300);  // 4 stalled edges
        run_txn(32'hEE105E10, 32'hFFFF_FFFF, 0, 0, 32'hAAAA_5555);  // cp14 -> undef
        run_txn(32'hE1A00000, 32'h8765_4321, 0, 0, 32'h5555_AAAA);  // not a copro op
        run_txn(32'hEE023F10, 32'hDEAD_BEEF, 0, 3, 32'h0);          // backpressure
        run_txn(32'hEE105F10, 32'h0,         2, 3, 32'hCAFE_F00D);  // stall + backpressure

        reset_mid_op("rst_wait_rd", 32'hEE3A7F35, 2, 1'b0, 2'b00);
        reset_mid_op("rst_issue",   32'hEE3A7F35, 2, 1'b1, 2'b01);

        // Randomized traffic.
        for (int t = 0; t < 300; t++) begin
            kind  = int'($urandom_range(0, 3));
            instr = $urandom;
            if (kind <= 2) begin
                instr[27:24] = 4'hE;
                instr[4]     = 1'b1;
                instr[11:8]  = 4'hF;
            end
            if (kind == 2) begin
                case ($urandom_range(0, 2))
                    0:       instr[11:8]  = 4'($urandom_range(0, 14));
                    1:       instr[4]     = 1'b0;
                    default: instr[27:24] = 4'($urandom_range(0, 13));
                endcase
            end
            run_txn(instr, $urandom,
                    ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 5)) : 0,
                    int'($urandom_range(0, 3)), $urandom);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
